// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU with valid/ready handshake and a carry register for
// multi-word ADC/SBC chaining.
//
// All computation is combinational on the accepted beat. The result is captured
// into stage 1. Stages 2..STAGES only delay it. A single global stall
// (advance = !out_valid || out_ready) moves every stage at once.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   a, b, op              operands (b doubles as shift/rotate amount) and opcode
//   out_valid / out_ready result beat handshake
//   y                     result
//   carry, overflow       carry/borrow out and signed overflow of the beat
//   zero, negative        y == 0 and y[WIDTH-1]
//   carry_flag            current stored carry register
module alu_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             carry_flag
);

    localparam int unsigned SW  = $clog2(WIDTH);
    localparam int unsigned PW  = WIDTH + 4;
    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);
    localparam logic [SW-1:0]    SAT_AMT = SW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_ADC   = 4'd8;
    localparam logic [3:0] OP_SBC   = 4'd9;
    localparam logic [3:0] OP_SLT   = 4'd10;
    localparam logic [3:0] OP_SLTU  = 4'd11;
    localparam logic [3:0] OP_ROL   = 4'd12;
    localparam logic [3:0] OP_ROR   = 4'd13;
    localparam logic [3:0] OP_PASSA = 4'd14;

    logic                 carry_q;
    logic [STAGES-1:0]    vld_q;
    logic [PW-1:0]        data_q [STAGES];

    logic                 advance;
    logic                 accept;
    logic                 is_arith;
    logic                 cin;
    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [SW-1:0]        sh_amt;
    logic [SW-1:0]        rot_amt;
    logic [2*WIDTH-1:0]   rol_w;
    logic [2*WIDTH-1:0]   ror_w;
    logic [WIDTH-1:0]     res_y;
    logic                 res_c;
    logic                 res_o;

    assign advance = !out_valid || out_ready;
    assign in_ready = advance;
    assign accept = in_valid && advance;

    always_comb begin
        is_arith = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADC) || (op == OP_SBC);
        cin = ((op == OP_ADC) || (op == OP_SBC)) ? carry_q : 1'b0;
        sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        // Bit WIDTH of the zero-extended difference is the borrow.
        diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
        sh_amt = (b >= WIDTH_V) ? SAT_AMT : b[SW-1:0];
        rot_amt = SW'(b % WIDTH_V);
        // Rotates fall out of a shift of the operand concatenated with itself.
        rol_w = {a, a} << rot_amt;
        ror_w = {a, a} >> rot_amt;

        res_y = '0;
        res_c = 1'b0;
        res_o = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                res_y = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_o = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                res_y = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_o = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND:   res_y = a & b;
            OP_OR:    res_y = a | b;
            OP_XOR:   res_y = a ^ b;
            OP_SLL:   res_y = a << sh_amt;
            OP_SRL:   res_y = a >> sh_amt;
            OP_SRA:   res_y = $signed(a) >>> sh_amt;
            OP_SLT:   res_y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  res_y = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_ROL:   res_y = rol_w[2*WIDTH-1:WIDTH];
            OP_ROR:   res_y = ror_w[WIDTH-1:0];
            OP_PASSA: res_y = a;
            default:  res_y = '0;
        endcase
    end

    // Carry register: updated only by accepted arithmetic beats, so ADC/SBC
    // accepted next cycle see the previous beat's carry without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else if (accept && is_arith) begin
            carry_q <= res_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid;
            // Bubbles carry zeros so nothing stale is ever presented.
            data_q[0] <= in_valid ? {res_y, res_c, res_o, (res_y == '0), res_y[MSB]} : '0;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i]  <= vld_q[i-1];
                data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid  = vld_q[STAGES-1];
    assign {y, carry, overflow, zero, negative} = data_q[STAGES-1];
    assign carry_flag = carry_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and backpressure bench for alu_pipe at WIDTH=8, STAGES=2.
module tb_alu_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;
    logic       carry_flag;

    int n_cmp = 0;
    int n_err = 0;

    alu_pipe #(.WIDTH(8), .STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .op         (op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .y          (y),
        .carry      (carry),
        .overflow   (overflow),
        .zero       (zero),
        .negative   (negative),
        .carry_flag (carry_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Compares {out_valid, y, carry, overflow, zero, negative} with a valid beat.
    task automatic check_beat(input string tag, input logic [7:0] ey, input logic ec,
                              input logic eo, input logic ez, input logic en);
        check(tag, {out_valid, y, carry, overflow, zero, negative}, {1'b1, ey, ec, eo, ez, en});
    endtask

    task automatic drive(input logic v, input logic [3:0] o, input logic [7:0] aa,
                         input logic [7:0] bb);
        in_valid = v;
        op = o;
        a = aa;
        b = bb;
        @(posedge clk);
        #1;
    endtask

    // Reference model, returns {y, carry, overflow, zero, negative}.
    function automatic logic [11:0] model(input logic [3:0] o, input logic [7:0] x,
                                          input logic [7:0] z, input logic cin);
        int r;
        int s;
        logic [7:0] ry;
        logic rc;
        logic ro;
        r = 0;
        ry = 8'h00;
        rc = 1'b0;
        ro = 1'b0;
        s = (int'(z) >= 8) ? 7 : int'(z);
        case (o)
            4'd0, 4'd8: begin
                r = int'(x) + int'(z) + ((o == 4'd8) ? int'(cin) : 0);
                ry = r[7:0];
                rc = (r > 255);
                ro = (x[7] == z[7]) && (ry[7] != x[7]);
            end
            4'd1, 4'd9: begin
                r = int'(x) - int'(z) - ((o == 4'd9) ? int'(cin) : 0);
                ry = r[7:0];
                rc = (r < 0);
                ro = (x[7] != z[7]) && (ry[7] != x[7]);
            end
            4'd2: ry = x & z;
            4'd3: ry = x | z;
            4'd4: ry = x ^ z;
            4'd5: ry = 8'(x << s);
            4'd6: ry = 8'(x >> s);
            4'd7: ry = 8'($signed(x) >>> s);
            4'd10: ry = ($signed(x) < $signed(z)) ? 8'h01 : 8'h00;
            4'd11: ry = (x < z) ? 8'h01 : 8'h00;
            4'd12: ry = 8'((x << (int'(z) % 8)) | (x >> (8 - (int'(z) % 8))));
            4'd13: ry = 8'((x >> (int'(z) % 8)) | (x << (8 - (int'(z) % 8))));
            4'd14: ry = x;
            default: ry = 8'h00;
        endcase
        return {ry, rc, ro, (ry == 8'h00), ry[7]};
    endfunction

    initial begin
        logic [11:0] sb[$];
        logic [11:0] exp_beat;
        logic        ref_cf;
        logic        need_new;
        logic        stalled;
        logic [7:0]  stall_y;
        int          sent;
        int          received;
        int          cycles;
        int          stale;

        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = 8'h00;
        b = 8'h00;
        op = 4'd0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_carry_flag", carry_flag, 1'b0);
        check("rst_y", y, 8'h00);

        // Carry chain
        drive(1'b1, 4'd0, 8'hFF, 8'h01);
        check("add_latency", out_valid, 1'b0);
        check("add_cflag", carry_flag, 1'b1);
        drive(1'b1, 4'd8, 8'h00, 8'h00);
        check_beat("add_ff_01", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0);
        // Borrow chain
        drive(1'b1, 4'd1, 8'h00, 8'h01);
        check_beat("adc_chain", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 8'h05, 8'h02);
        check_beat("sub_00_01", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        check("sbc_cflag", carry_flag, 1'b0);
        drive(1'b1, 4'd1, 8'h80, 8'h01);
        check_beat("sbc_chain", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        // Shift / rotate bounds, reserved op, compares
        drive(1'b1, 4'd5, 8'h01, 8'h09);
        check_beat("sub_ovf", 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'd7, 8'h80, 8'h08);
        check_beat("sll_sat", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd13, 8'h01, 8'h09);
        check_beat("sra_sat", 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd12, 8'h81, 8'h01);
        check_beat("ror_mod", 8'h80, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd15, 8'h12, 8'h34);
        check_beat("rol_1", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd10, 8'h80, 8'h01);
        check_beat("op15", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'd11, 8'h80, 8'h01);
        check_beat("slt", 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd6, 8'hF0, 8'h04);
        check_beat("sltu", 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'd4, 8'hA5, 8'hFF);
        check_beat("srl", 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        check_beat("xor", 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed stall
        drive(1'b1, 4'd3, 8'h0F, 8'h30);
        out_ready = 1'b0;
        drive(1'b1, 4'd14, 8'h77, 8'h00);
        check_beat("stall_or", 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_in_ready", in_ready, 1'b0);
        drive(1'b1, 4'd0, 8'h01, 8'h01);
        drive(1'b1, 4'd0, 8'h01, 8'h01);
        check_beat("stall_hold", 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0);
        check("stall_in_ready2", in_ready, 1'b0);
        out_ready = 1'b1;
        drive(1'b1, 4'd0, 8'h01, 8'h01);
        check_beat("stall_passa", 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        check_beat("stall_add", 8'h02, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 8'h00, 8'h00);
        check("stall_drain", out_valid, 1'b0);

        // Random backpressure against the model
        ref_cf = 1'b0;
        need_new = 1'b1;
        sent = 0;
        received = 0;
        cycles = 0;
        while (received < 10 && cycles < 300) begin
            cycles++;
            out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 10);
            if (in_valid && need_new) begin
                op = 4'($urandom_range(0, 14));
                a = 8'($urandom_range(0, 255));
                b = 8'($urandom_range(0, 255));
                need_new = 1'b0;
            end
            #1;
            check("bp_in_ready", in_ready, !(out_valid && !out_ready));
            stalled = out_valid && !out_ready;
            stall_y = y;
            if (in_valid && in_ready) begin
                exp_beat = model(op, a, b, ref_cf);
                sb.push_back(exp_beat);
                if (op == 4'd0 || op == 4'd1 || op == 4'd8 || op == 4'd9) begin
                    ref_cf = exp_beat[3];
                end
                sent++;
                need_new = 1'b1;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("bp_extra_beat", 1'b1, 1'b0);
                end else begin
                    check("bp_result", {y, carry, overflow, zero, negative}, sb.pop_front());
                end
                received++;
            end
            @(posedge clk);
            #1;
            if (stalled) begin
                check("bp_y_stable", y, stall_y);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_received", received, 10);
        check("bp_carry_flag", carry_flag, ref_cf);

        // Reset with two beats in flight
        drive(1'b1, 4'd0, 8'hFF, 8'h01);
        drive(1'b1, 4'd4, 8'h01, 8'h01);
        check("inflight_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_carry_flag", carry_flag, 1'b0);
        check("midrst_y", y, 8'h00);
        in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        stale = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (out_valid) stale++;
        end
        check("no_stale", stale, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
